// File: rtl/keccak_padder.sv
// SHA3 message padder: packs 64-bit little-endian words into rate lanes,
// applies pad10*1 with domain separation and hands blocks to the core.
module keccak_padder #(
  parameter int          WIDTH      = 64,
  parameter int          RATE_LANES = 17,
  parameter logic [7:0]  DOMAIN     = 8'h06
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            msg_data,
  input  logic [3:0]                  msg_bytes,
  input  logic                        msg_valid,
  input  logic                        msg_last,
  output logic                        msg_ready,
  output logic [0:4][0:4][WIDTH-1:0]  blk_data,
  output logic                        blk_valid,
  output logic                        blk_last,
  input  logic                        blk_ready,
  output logic [4:0]                  lane_cnt
);

  localparam int LAST = RATE_LANES - 1;
  localparam int IW   = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    PAD
  } state_e;

  state_e                           state_q, state_d;
  logic [RATE_LANES-1:0][WIDTH-1:0] lanes_q, lanes_d;
  logic [4:0]                       cnt_q, cnt_d;
  logic                             pend_q, pend_d;
  logic                             last_q, last_d;

  logic [3:0]       word_bytes;
  logic             full;
  logic [5:0]       sh;
  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] dom_lane;
  logic [WIDTH-1:0] dom_at;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    nidx;

  // Illegal byte counts collapse to a full word.
  always_comb begin
    word_bytes = msg_bytes;
    if (!msg_last || (msg_bytes > 4'd8)) begin
      word_bytes = 4'd8;
    end
  end

  assign full     = (word_bytes == 4'd8);
  assign sh       = {word_bytes[2:0], 3'b000};
  assign one      = WIDTH'(1);
  assign mask     = (one << sh) - one;
  assign dom_lane = {{(WIDTH-8){1'b0}}, DOMAIN};
  assign dom_at   = dom_lane << sh;
  assign idx      = cnt_q[IW-1:0];
  assign nidx     = IW'(cnt_q + 5'd1);

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (msg_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (!msg_last) begin
            lanes_d[idx] = msg_data;
            if (cnt_q == 5'(LAST)) begin
              state_d = SEND;
              last_d  = 1'b0;
            end
          end else if (!full) begin
            lanes_d[idx] = (msg_data & mask) | dom_at;
            lanes_d[LAST][WIDTH-1 -: 8] =
              lanes_d[LAST][WIDTH-1 -: 8] | 8'h80;
            state_d = SEND;
            last_d  = 1'b1;
          end else if (cnt_q != 5'(LAST)) begin
            lanes_d[idx]  = msg_data;
            lanes_d[nidx] = dom_lane;
            lanes_d[LAST][WIDTH-1 -: 8] =
              lanes_d[LAST][WIDTH-1 -: 8] | 8'h80;
            state_d = SEND;
            last_d  = 1'b1;
          end else begin
            // Word fills the block exactly: padding needs its own block.
            lanes_d[idx] = msg_data;
            state_d      = SEND;
            last_d       = 1'b0;
            pend_d       = 1'b1;
          end
        end
      end
      SEND: begin
        if (blk_ready) begin
          lanes_d = '0;
          cnt_d   = 5'd0;
          last_d  = 1'b0;
          state_d = pend_q ? PAD : FILL;
        end
      end
      PAD: begin
        lanes_d = '0;
        lanes_d[0][7:0] = DOMAIN;
        lanes_d[LAST][WIDTH-1 -: 8] =
          lanes_d[LAST][WIDTH-1 -: 8] | 8'h80;
        pend_d  = 1'b0;
        last_d  = 1'b1;
        state_d = SEND;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      lanes_q <= '0;
      cnt_q   <= 5'd0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
    end
  end

  assign msg_ready = (state_q == FILL);
  assign blk_valid = (state_q == SEND);
  assign blk_last  = last_q;
  assign lane_cnt  = cnt_q;

  // Lane i sits at [i%5][i/5]; capacity lanes are tied to zero.
  for (genvar x = 0; x < 5; x++) begin : g_x
    for (genvar y = 0; y < 5; y++) begin : g_y
      localparam int IDX = x + 5 * y;
      if (IDX < RATE_LANES) begin : g_rate
        assign blk_data[x][y] = lanes_q[IDX];
      end else begin : g_cap
        assign blk_data[x][y] = '0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_padder.sv
// Bench for keccak_padder: byte-level pad10*1 model feeds a block
// scoreboard; scenario tasks add timing and boundary checks.
module tb_keccak_padder;

  localparam int         RATE = 17;
  localparam int         RB   = RATE * 8;
  localparam logic [7:0] DOM  = 8'h06;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [63:0]             msg_data;
  logic [3:0]              msg_bytes;
  logic                    msg_valid;
  logic                    msg_last;
  logic                    msg_ready;
  logic [0:4][0:4][63:0]   blk_data;
  logic                    blk_valid;
  logic                    blk_last;
  logic                    blk_ready;
  logic [4:0]              lane_cnt;

  typedef struct packed {
    logic              last;
    logic [24:0][63:0] lane;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  keccak_padder #(
    .WIDTH(64),
    .RATE_LANES(RATE),
    .DOMAIN(DOM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .msg_data(msg_data),
    .msg_bytes(msg_bytes),
    .msg_valid(msg_valid),
    .msg_last(msg_last),
    .msg_ready(msg_ready),
    .blk_data(blk_data),
    .blk_valid(blk_valid),
    .blk_last(blk_last),
    .blk_ready(blk_ready),
    .lane_cnt(lane_cnt)
  );

  always @(negedge clk) begin
    blk_t              e;
    logic [24:0][63:0] act;
    int                bl;
    if (!rst && blk_valid && blk_ready) begin
      for (int i = 0; i < 25; i++) act[i] = blk_data[i % 5][i / 5];
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_block: got block, expected none");
      end else begin
        e  = exp_q.pop_front();
        bl = -1;
        for (int i = 0; i < 25; i++)
          if (bl < 0 && act[i] !== e.lane[i]) bl = i;
        if (bl >= 0) begin
          bad++;
          $display("FAIL blk_data lane %0d: got %h expected %h",
                   bl, act[bl], e.lane[bl]);
        end
        total++;
        if (blk_last !== e.last) begin
          bad++;
          $display("FAIL blk_last: got %b expected %b", blk_last, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && msg_valid && msg_ready &&
        ((msg_bytes > 4'd8) || (!msg_last && msg_bytes != 4'd8))) begin
      bad++;
      $display("FAIL illegal_word: bytes=%0d last=%b", msg_bytes, msg_last);
    end
  end

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_expected();
    logic [7:0] p[$];
    blk_t       e;
    int         nb;
    p = msg_q;
    p.push_back(DOM);
    while (p.size() % RB != 0) p.push_back(8'h00);
    p[p.size() - 1] = p[p.size() - 1] | 8'h80;
    nb = p.size() / RB;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int l = 0; l < RATE; l++)
        for (int k = 0; k < 8; k++)
          e.lane[l][8 * k +: 8] = p[b * RB + l * 8 + k];
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_msg();
    int          n, nw, b, t;
    logic [63:0] d;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      b = n - 8 * w;
      if (b > 8) b = 8;
      d = {8{8'hEE}};
      for (int k = 0; k < b; k++) d[8 * k +: 8] = msg_q[8 * w + k];
      msg_data  = d;
      msg_bytes = 4'(b);
      msg_last  = (w == nw - 1);
      msg_valid = 1'b1;
      t = 0;
      while (!msg_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (!msg_ready) begin
        total++;
        bad++;
        $display("FAIL msg_accept: msg_ready=%b expected 1 within 200", msg_ready);
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d blocks outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (msg_ready !== 1'b1 || blk_valid !== 1'b0 || blk_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: rdy=%b vld=%b last=%b expected 1 0 0",
               msg_ready, blk_valid, blk_last);
    end
    total++;
    if (lane_cnt !== 5'd0 || blk_data !== '0) begin
      bad++;
      $display("FAIL reset_state: lane_cnt=%0d data_nonzero=%b expected 0 0",
               lane_cnt, blk_data != '0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_empty();
    blk_ready = 1'b1;
    msg_q.delete();
    push_expected();
    drive_msg();
    total++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      bad++;
      $display("FAIL empty_latency: vld=%b last=%b expected 1 1", blk_valid, blk_last);
    end
    total++;
    if (blk_data[0][0] !== 64'h06 || blk_data[1][3] !== 64'h8000000000000000) begin
      bad++;
      $display("FAIL empty_lanes: lane0=%h lane16=%h expected 06 8000000000000000",
               blk_data[0][0], blk_data[1][3]);
    end
    drain();
  endtask

  task automatic test_abc();
    blk_ready = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    push_expected();
    drive_msg();
    total++;
    if (blk_valid !== 1'b1 || blk_data[0][0] !== 64'h0000000006636261) begin
      bad++;
      $display("FAIL abc_lane0: vld=%b lane0=%h expected 1 0000000006636261",
               blk_valid, blk_data[0][0]);
    end
    drain();
  endtask

  task automatic test_full_pad();
    blk_ready = 1'b0;
    rand_msg(RB);
    push_expected();
    drive_msg();
    total++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b0) begin
      bad++;
      $display("FAIL full_blk1: vld=%b last=%b expected 1 0", blk_valid, blk_last);
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    total++;
    if (blk_valid !== 1'b0 || msg_ready !== 1'b0) begin
      bad++;
      $display("FAIL pad_cycle: vld=%b rdy=%b expected 0 0", blk_valid, msg_ready);
    end
    @(posedge clk); #1;
    total++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1 ||
        blk_data[0][0] !== 64'h06 || blk_data[1][3] !== 64'h8000000000000000) begin
      bad++;
      $display("FAIL pad_blk: vld=%b last=%b lane0=%h lane16=%h expected 1 1 06 8000000000000000",
               blk_valid, blk_last, blk_data[0][0], blk_data[1][3]);
    end
    blk_ready = 1'b1;
    drain();
  endtask

  task automatic test_tail7();
    blk_ready = 1'b1;
    rand_msg(RB - 8);
    msg_q.push_back(8'h11); msg_q.push_back(8'hFF);
    msg_q.push_back(8'hEE); msg_q.push_back(8'hDD);
    msg_q.push_back(8'hCC); msg_q.push_back(8'hBB);
    msg_q.push_back(8'hAA);
    push_expected();
    drive_msg();
    total++;
    if (blk_data[1][3] !== 64'h86AABBCCDDEEFF11 || blk_last !== 1'b1) begin
      bad++;
      $display("FAIL tail7: lane16=%h last=%b expected 86AABBCCDDEEFF11 1",
               blk_data[1][3], blk_last);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [0:4][0:4][63:0] snap;
    logic                  sl;
    blk_ready = 1'b0;
    rand_msg(RB);
    push_expected();
    drive_msg();
    snap = blk_data;
    sl   = blk_last;
    msg_valid = 1'b1;
    msg_bytes = 4'd8;
    msg_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      msg_data = {$urandom, $urandom};
      @(posedge clk); #1;
      total++;
      if (blk_data !== snap || blk_last !== sl ||
          msg_ready !== 1'b0 || blk_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold c%0d: vld=%b rdy=%b stable=%b expected 1 0 1",
                 c, blk_valid, msg_ready, (blk_data === snap && blk_last === sl));
      end
    end
    msg_valid = 1'b0;
    blk_ready = 1'b1;
    drain();
    total++;
    if (lane_cnt !== 5'd0 || msg_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_after: lane_cnt=%0d rdy=%b expected 0 1", lane_cnt, msg_ready);
    end
    rand_msg(20);
    push_expected();
    drive_msg();
    drain();
  endtask

  task automatic test_reset_mid();
    blk_ready = 1'b1;
    msg_bytes = 4'd8;
    msg_last  = 1'b0;
    for (int w = 0; w < 5; w++) begin
      msg_data  = {$urandom, $urandom};
      msg_valid = 1'b1;
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    total++;
    if (lane_cnt !== 5'd5) begin
      bad++;
      $display("FAIL partial_cnt: lane_cnt=%0d expected 5", lane_cnt);
    end
    rst = 1'b1;
    #1;
    total++;
    if (blk_valid !== 1'b0 || lane_cnt !== 5'd0 || msg_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: vld=%b cnt=%0d rdy=%b expected 0 0 1",
               blk_valid, lane_cnt, msg_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    push_expected();
    drive_msg();
    total++;
    if (blk_data[0][0] !== 64'h0000000006636261 || blk_data[1][3] !== 64'h8000000000000000) begin
      bad++;
      $display("FAIL abc_after_reset: lane0=%h lane16=%h expected 0000000006636261 8000000000000000",
               blk_data[0][0], blk_data[1][3]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lens[12] = '{1, 7, 8, 9, 127, 128, 129, 135, 137, 200, 272, 0};
    blk_ready = 1'b1;
    foreach (lens[i]) begin
      rand_msg(lens[i]);
      push_expected();
      drive_msg();
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    msg_data  = '0;
    msg_bytes = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    blk_ready = 1'b0;
    test_reset();
    test_empty();
    test_abc();
    test_full_pad();
    test_tail7();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
- Message-side front end of the SHA3 datapath.
- Accepts a little-endian 64-bit word stream and packs it into rate lanes of a 5x5xWIDTH Keccak state.
- Applies SHA3 pad10*1 with domain separation.
- Hands complete blocks to the absorb/permutation core over a valid/ready handshake, marking the final block with blk_last.

Parameters:
- WIDTH, 64, lane width in bits; only 64 is supported.
- RATE_LANES, 17, lanes per block (17 = SHA3-256, 9 = SHA3-512, 21 = SHAKE128).
- DOMAIN, 8'h06, domain-separation byte (8'h1F for SHAKE).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- msg_data  in  WIDTH  message word; byte 0 is bits [7:0].
- msg_bytes  in  4  valid bytes in msg_data, 0..8; must be 8 unless msg_last.
- msg_valid  in  1  word present.
- msg_last  in  1  final word of the message.
- msg_ready  out  1  padder accepts a word this cycle.
- blk_data  out  [0:4][0:4][WIDTH-1:0]  block; lane i maps to blk_data[i%5][i/5].
- blk_valid  out  1  block presented.
- blk_last  out  1  block is the final, padded block.
- blk_ready  in  1  core takes the block this cycle.
- lane_cnt  out  5  index of the next lane to fill (status).

Behaviour:
- Reset, asynchronous, any state: state=FILL, lane buffer all zero, lane_cnt=0, pad_pending=0, msg_ready=1, blk_valid=0, blk_last=0.
- Word transfer occurs on msg_valid&&msg_ready. Block transfer occurs on blk_valid&&blk_ready.
- Single block buffer: msg_ready=1 only in FILL; blk_valid=1 only in SEND.
- blk_data, blk_last are stable from blk_valid rise to transfer.
- States:
  - FILL, normal word (!msg_last, bytes=8): lane[lane_cnt]<=msg_data; lane_cnt++. If lane_cnt was RATE_LANES-1 -> SEND, blk_last=0.
  - FILL, last word with b bytes, lane L=lane_cnt:
    - b<8: lane L <= data bytes 0..b-1, byte b=DOMAIN, rest 0. Lane RATE_LANES-1 byte 7 |= 8'h80 (OR, so L=RATE_LANES-1 with b=7 gives byte 7 = DOMAIN|0x80 = 8'h86). -> SEND, blk_last=1.
    - b=8 and L<RATE_LANES-1: lane L <= data, lane L+1 byte 0=DOMAIN, 0x80 in last rate lane as above. -> SEND, blk_last=1.
    - b=8 and L=RATE_LANES-1: lane L <= data. -> SEND, blk_last=0, pad_pending=1.
    - b=0: DOMAIN at lane L byte 0 (empty message or empty tail), plus 0x80 as above. -> SEND, blk_last=1.
  - SEND: hold until blk_ready.
    - On transfer, clear buffer, lane_cnt=0.
    - If pad_pending: PAD. Else -> FILL.
  - PAD (one cycle, msg_ready=0): buffer = lane0 byte0=DOMAIN, lane RATE_LANES-1 byte7=8'h80; pad_pending=0. -> SEND, blk_last=1.
- Lanes RATE_LANES..24 (capacity) are always zero in blk_data.
- Latency: blk_valid rises the cycle after the word completing the block is accepted; the pad-only block is 2 cycles after the previous block's transfer.
- Next message may begin in FILL the cycle after the last block's transfer; no idle gap is required.
- msg_bytes>8, or <8 without msg_last, is illegal. Bench asserts it never occurs; RTL treats such a word as 8 bytes.
- msg inputs are ignored outside FILL. blk_ready is ignored outside SEND.
- Reset mid-block discards partial data; no block is emitted.

Test Plan:
- Empty message: msg_valid, msg_last, msg_bytes=0 -> one block, lane0=64'h06, lane16=64'h8000000000000000, all else 0, blk_last=1.
- "abc": msg_data=64'h636261, bytes=3, last -> lane0=64'h0000000006636261, lane16=64'h80<<56, blk_last=1, blk_valid one cycle after accept.
- 17 full words with last on the 17th -> block 1 = data lanes, blk_last=0; then block 2 lane0=64'h06, lane16=64'h8000000000000000, blk_last=1.
- 16 full words + last word 64'h00AABBCCDDEEFF11, bytes=7 -> lane16=64'h86AABBCCDDEEFF11, blk_last=1, single block.
- Backpressure: 17 words, blk_ready low 10 cycles -> blk_data/blk_last stable, msg_ready=0 throughout, no words dropped; next message starts at lane_cnt=0.
- Reset asserted after 5 words -> blk_valid=0, lane_cnt=0, msg_ready=1 immediately. "abc" then yields the same block as scenario 2.
